// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state type and op classification
// helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

    // Signed variants get magnitude conversion and sign fixup.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that occupy the engine (as opposed to MTHI/MTLO register moves).
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the engine, purely combinational.
//   multiply: shift-add, {acc,q} shifts right, q[0] selects adding i_d.
//   divide:   restoring, {acc,q} shifts left, quotient bits enter q[0].
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_div,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem;
    logic [WIDTH:0] w_diff;

    // Next partial product / partial remainder for the selected mode.
    always_comb begin
        w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_d} : {(WIDTH+1){1'b0}});
        w_rem  = {i_acc, i_q[WIDTH-1]};
        w_diff = w_rem - {1'b0, i_d};
        if (i_div) begin
            // The partial remainder is always below 2*divisor, so bit WIDTH
            // of the difference is a clean borrow flag.
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_rem[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine owning the HI/LO pair.
// IDLE accepts an op, CALC runs WIDTH radix-2 steps on magnitudes, FIX
// applies sign correction and boundary results and writes HI/LO.
// Optional build macro: MULDIV_FAST_MUL_EN -- MULT/MULTU use a single-cycle
// combinational product and go straight from IDLE to FIX.
// CNT_W must satisfy 2**CNT_W > WIDTH.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0]   ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    md_state_e        r_state;
    md_state_e        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_a_orig;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_b_zero;
    logic             r_ovf;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {ZERO, w_abs_a} * {ZERO, w_abs_b};
`endif

    assign w_signed = md_is_signed(op);
    // Most-negative maps to 2**(WIDTH-1), which is exact as an unsigned magnitude.
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? (~a + ONE) : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? (~b + ONE) : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_d   (r_d),
        .i_div (r_div),
        .o_acc (w_acc_next),
        .o_q   (w_q_next)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides everything, including a new start.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && md_is_arith(op)) begin
`ifdef MULDIV_FAST_MUL_EN
                        if (md_is_div(op)) begin
                            w_next_state = S_CALC;
                        end else begin
                            w_next_state = S_FIX;
                        end
`else
                        w_next_state = S_CALC;
`endif
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        w_next_state = S_FIX;
                    end else begin
                        w_next_state = S_CALC;
                    end
                end
                S_FIX:   w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Sign correction and boundary results presented to HI/LO in FIX.
    always_comb begin
        w_prod   = {r_acc, r_q};
        w_quo    = r_q;
        w_rem    = r_acc;
        w_fix_hi = ZERO;
        w_fix_lo = ZERO;
        if (r_neg_q) begin
            w_prod = ~{r_acc, r_q} + ONE_2W;
            w_quo  = ~r_q + ONE;
        end else begin
            w_prod = {r_acc, r_q};
            w_quo  = r_q;
        end
        if (r_neg_r) begin
            w_rem = ~r_acc + ONE;
        end else begin
            w_rem = r_acc;
        end
        if (!r_div) begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end else if (r_b_zero) begin
            w_fix_hi = r_a_orig;
            w_fix_lo = ALL_ONES;
        end else if (r_ovf) begin
            w_fix_hi = ZERO;
            w_fix_lo = r_a_orig;
        end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end
    end

    // Operand capture, iteration, HI/LO writes and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= ZERO;
            r_q      <= ZERO;
            r_d      <= ZERO;
            r_a_orig <= ZERO;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_ovf    <= 1'b0;
            r_hi     <= ZERO;
            r_lo     <= ZERO;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!flush) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            case (op)
                                MD_MTHI: r_hi <= a;
                                MD_MTLO: r_lo <= a;
                                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                    r_div    <= md_is_div(op);
                                    r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    r_neg_r  <= w_signed & a[WIDTH-1];
                                    r_b_zero <= (b == ZERO);
                                    r_ovf    <= (op == MD_DIV) && (a == MOST_NEG) && (b == ALL_ONES);
                                    r_a_orig <= a;
                                    r_cnt    <= CNT_W'(WIDTH - 1);
                                    r_acc    <= ZERO;
                                    if (md_is_div(op)) begin
                                        r_q <= w_abs_a;
                                        r_d <= w_abs_b;
                                    end else begin
                                        r_q <= w_abs_b;
                                        r_d <= w_abs_a;
                                    end
`ifdef MULDIV_FAST_MUL_EN
                                    // Product lands directly in {acc,q}; FIX handles the sign.
                                    if (!md_is_div(op)) begin
                                        r_acc <= w_fast_prod[2*WIDTH-1:WIDTH];
                                        r_q   <= w_fast_prod[WIDTH-1:0];
                                    end
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_CALC: begin
                        r_acc <= w_acc_next;
                        r_q   <= w_q_next;
                        if (r_cnt != {CNT_W{1'b0}}) begin
                            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    S_FIX: begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass  = 0;
    int n_total = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one MULT/DIV op, optionally poke start while busy, wait for done.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat, input bit poke);
        int n;
        start = 1'b1; op = o; a = va; b = vb;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        n = 0;
        if (poke) begin
            start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
            tick();
            n++;
            start = 1'b0;
        end
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"},  64'(n), 64'(exp_lat));
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        check({tag, "_hi"},   {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"},   {32'd0, lo}, {32'd0, exp_lo});
        tick();
        check({tag, "_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; op = MD_MULT; a = 32'd0; b = 32'd0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi",   {32'd0, hi}, 64'd0);
        check("rst_lo",   {32'd0, lo}, 64'd0);

        // Register moves at idle
        start = 1'b1; op = MD_MTHI; a = 32'h1234;
        tick();
        start = 1'b0;
        check("mthi_hi",   {32'd0, hi}, 64'h1234);
        check("mthi_done", {63'd0, done}, 64'd0);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        start = 1'b1; op = MD_MTLO; a = 32'h5678;
        tick();
        start = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'h5678);
        check("mtlo_hi", {32'd0, hi}, 64'h1234);

        // Arithmetic vectors
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
        run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
        run_op("div_negb",  MD_DIV,   32'd100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFF2, DIV_LAT, 1'b0);
        run_op("divu_big",  MD_DIVU,  32'hFFFF_FFFF, 32'd10, 32'h5, 32'h1999_9999, DIV_LAT, 1'b0);
        run_op("divu_z",    MD_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
        run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT, 1'b0);
        run_op("div_z",     MD_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
        run_op("mult_mn",   MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_LAT, 1'b0);
        run_op("multu_ign", MD_MULTU, 32'd5, 32'd6, 32'h0, 32'd30, MUL_LAT, 1'b1);

        // Flush mid-divide
        start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("fl_busy_pre", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", {63'd0, busy}, 64'd0);
        check("fl_hi",   {32'd0, hi}, 64'd0);
        check("fl_lo",   {32'd0, lo}, 64'd30);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("fl_nodone", 64'(done_seen), 64'd0);
        check("fl_lo_kept", {32'd0, lo}, 64'd30);

        // Flush wins over start on the same edge
        start = 1'b1; op = MD_MTHI; a = 32'hBEEF; flush = 1'b1;
        tick();
        start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd2; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flpri_hi",   {32'd0, hi}, 64'd0);
        check("flpri_busy", {63'd0, busy}, 64'd0);

        // Reset during CALC
        start = 1'b1; op = MD_MULT; a = 32'hFFFF_FFFD; b = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstc_busy", {63'd0, busy}, 64'd0);
        check("rstc_done", {63'd0, done}, 64'd0);
        check("rstc_hi",   {32'd0, hi}, 64'd0);
        check("rstc_lo",   {32'd0, lo}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
